// File: rtl/mx2_arb_pkg.sv
// Shared types for the two-source mx2 bus arbiter: FSM state encoding and counter sizing.
package mx2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    // Beat counter must hold MAXLEN-1 with headroom, so one bit beyond clog2.
    function automatic int cnt_w(input int maxlen);
        return $clog2(maxlen) + 1;
    endfunction

endpackage

// File: rtl/mx2_arb_if.sv
// Stream bundle between the two producers, the arbiter and the single consumer port.
interface mx2_arb_if #(
    parameter int W = 8
);
    logic [W-1:0] i0;
    logic         vld0;
    logic         lst0;
    logic         rdy0;
    logic [W-1:0] i1;
    logic         vld1;
    logic         lst1;
    logic         rdy1;
    logic [W-1:0] q;
    logic         q_vld;
    logic         q_rdy;
    logic         cmd;
    logic [1:0]   gnt;

    modport slave (
        input  i0, vld0, lst0, i1, vld1, lst1, q_rdy,
        output rdy0, rdy1, q, q_vld, cmd, gnt
    );

    modport master (
        output i0, vld0, lst0, i1, vld1, lst1, q_rdy,
        input  rdy0, rdy1, q, q_vld, cmd, gnt
    );
endinterface

// File: rtl/mx2_bus.sv
// mx2_bus: W-bit shared data mux built from mx2_x2 cells on a common select.
// Latency: combinational, one mx2 delay from i_cmd or data.
// Backpressure: none, datapath only; flow control lives in the arbiter.
module mx2_bus #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_i0,
    input  logic [W-1:0] i_i1,
    input  logic         i_cmd,
    output logic [W-1:0] o_q
);
    for (genvar g = 0; g < W; g++) begin : g_bit
        mx2_x2 u_mx (
            .i0  (i_i0[g]),
            .i1  (i_i1[g]),
            .cmd (i_cmd),
            .q   (o_q[g])
        );
    end
endmodule

// File: rtl/mx2_x2.sv
// mx2_x2: behavioural model of the 2:1 mux standard cell, q = cmd ? i1 : i0.
// Latency: purely combinational, one cell delay.
// Backpressure: none, stateless.
module mx2_x2 (
    input  logic i0,
    input  logic i1,
    input  logic cmd,
    output logic q
);
    assign q = cmd ? i1 : i0;
endmodule

// File: rtl/mx2_arb.sv
// mx2_arb: round-robin packet arbiter driving the registered select of a shared mx2 bus.
// Latency: grant one edge after request; back-to-back switch on the last beat with no bubble.
// Backpressure: owner's ready mirrors q_rdy; the non-owner is held off until release.
module mx2_arb
    import mx2_arb_pkg::*;
#(
    parameter int W      = 8,
    parameter int MAXLEN = 16
) (
    input logic       ck,
    input logic       rst,
    mx2_arb_if.slave  bus
);
    localparam int            CW  = cnt_w(MAXLEN);
    localparam logic [CW-1:0] LIM = CW'(MAXLEN - 1);

    state_t        r_state;
    logic          r_cmd;
    logic          r_ptr;
    logic [1:0]    r_gnt;
    logic [CW-1:0] r_cnt;

    logic w_g0;
    logic w_g1;
    logic w_idle;
    logic w_qvld;
    logic w_xfer;
    logic w_rel;
    logic w_oth_vld;
    logic w_enter;
    logic w_pick;

    assign w_g0   = (r_state == G0);
    assign w_g1   = (r_state == G1);
    assign w_idle = (r_state == IDLE);

    assign w_qvld    = (w_g0 & bus.vld0) | (w_g1 & bus.vld1);
    assign w_xfer    = w_qvld & bus.q_rdy;
    // Release on packet end or when the grant has used its beat budget.
    assign w_rel     = w_xfer & ((w_g1 ? bus.lst1 : bus.lst0) | (r_cnt == LIM));
    assign w_oth_vld = w_g1 ? bus.vld0 : bus.vld1;

    // A new grant starts from IDLE on any request, or directly on release if the peer waits.
    assign w_enter = w_idle ? (bus.vld0 | bus.vld1) : (w_rel & w_oth_vld);
    assign w_pick  = w_idle ? ((bus.vld0 & bus.vld1) ? r_ptr : bus.vld1) : w_g0;

    assign bus.q_vld = w_qvld;
    assign bus.rdy0  = w_g0 & bus.q_rdy;
    assign bus.rdy1  = w_g1 & bus.q_rdy;
    assign bus.cmd   = r_cmd;
    assign bus.gnt   = r_gnt;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cmd   <= 1'b0;
            r_ptr   <= 1'b0;
            r_gnt   <= 2'b00;
            r_cnt   <= '0;
        end else if (w_enter) begin
            r_state <= w_pick ? G1 : G0;
            r_cmd   <= w_pick;
            r_gnt   <= {w_pick, ~w_pick};
            r_ptr   <= ~w_pick;
            r_cnt   <= '0;
        end else if (w_xfer) begin
            if (w_rel) begin
                r_state <= IDLE;
                r_gnt   <= 2'b00;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    mx2_bus #(.W(W)) u_bus (
        .i_i0  (bus.i0),
        .i_i1  (bus.i1),
        .i_cmd (r_cmd),
        .o_q   (bus.q)
    );
endmodule

// File: doc/mx2_arb.md
# mx2_arb

Two-requester packet arbiter for a shared W-bit 2:1 mux bus built from mx2_x2 cells. It accepts valid/ready/last streams on i0 and i1, grants one source at a time with round-robin fairness and forced release after MAXLEN beats, and drives the registered mux select cmd. The block sits between two producer blocks and a single consumer port, for example a shared write bus or output FIFO, in the C4M.Sky130 StdCellLib flow.

## Interface
Parameters:
- W, 8, data width (1..64).
- MAXLEN, 16, maximum beats per grant before forced release (2..256).

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- i0  in  W  data, source 0.
- vld0  in  1  source 0 valid.
- lst0  in  1  source 0 last beat of packet.
- rdy0  out  1  source 0 ready.
- i1  in  W  data, source 1.
- vld1  in  1  source 1 valid.
- lst1  in  1  source 1 last beat of packet.
- rdy1  out  1  source 1 ready.
- q  out  W  muxed data, equal to cmd ? i1 : i0.
- q_vld  out  1  output valid.
- q_rdy  in  1  consumer ready.
- cmd  out  1  registered mux select; 1 selects i1.
- gnt  out  2  one-hot grant, bit k set while source k owns the bus.

## Operation
- FSM states are IDLE, G0 and G1. Reset values: state=IDLE, cmd=0, gnt=00, ptr=0 (source 0 preferred), cnt=0, rdy0=rdy1=q_vld=0.
- IDLE: if only vldk=1, go to Gk. If both are set, go to G<ptr>. Otherwise stay in IDLE. On entry to Gk: cmd<=k, gnt<=onehot(k), ptr<=~k, cnt<=0.
- In Gk: q_vld=vldk; rdyk=q_rdy; the other source's ready is 0. q is combinational through the mux.
- A beat transfers when vldk & q_rdy. Each beat increments cnt (width ceil(log2(MAXLEN))+1).
- Release happens on a transfer where lstk=1 or cnt==MAXLEN-1.
  - On release, if the other source is valid in the same cycle, switch directly to G(~k) with no idle bubble. ptr points at k again.
  - Otherwise go to IDLE. cmd holds its value and gnt becomes 00.
- Forced release mid-packet: the source keeps its remaining beats and competes again. The packet is split, and downstream must accept split packets.
- If vldk drops while in Gk, the grant is held; the block does not re-arbitrate. Only lst or MAXLEN releases the bus.
- IDLE outputs are q_vld=0 and rdy0=rdy1=0.
- On rst assertion mid-packet, all state clears immediately and asynchronously. Any beat in flight is lost; sources must re-send.

## Timing
- Grant latency: vldk rising in IDLE leads to gnt/cmd on the next ck edge. The first beat can transfer in that next cycle, so there is a 1-cycle arbitration bubble.
- Back-to-back switch: the last beat of k in cycle n gives G(~k) at edge n+1, with 0 bubbles.
- cmd changes only on ck edges and never while a beat is mid-cycle. q settles one mx2 delay after cmd or the data input changes.
- q_vld/rdyk are combinational from registered state plus vldk/q_rdy. There is no combinational path from q_rdy to q_vld.
- Throughput: 1 beat/cycle while granted.

## Structure
- Shared package mx2_arb_pkg holds the state enum {IDLE, G0, G1} and the function for cnt width.
- Sub-module mx2_bus(W) instantiates W mx2_x2 cells with a common cmd. It is the only datapath. The FSM, ptr and cnt stay in mx2_arb.

## Test plan
- Single source: with vld0=1 and lst0 set on the 3rd beat, expect gnt=01 one cycle after vld0, 3 beats with q=i0, then IDLE with cmd held at 0.
- Simultaneous: with vld0=vld1=1 from reset, expect G0 first (ptr=0), then at lst0 a direct switch to G1 with cmd=1 and no bubble, then alternation on every packet.
- Forced release: with MAXLEN=4, source 1 sends a 10-beat packet while vld0=1. Expect 4 beats on i1, then 1 packet on i0, then 4 more beats on i1.
- Backpressure: drive q_rdy toggling 1,0,1,0 during G0. Expect rdy0 to mirror q_rdy, cnt to advance only on transfers, and no loss or duplication of beats (scoreboard i0 against q).
- Reset mid-packet: assert rst asynchronously between edges in G1 on beat 2. Expect cmd=0, gnt=00 and q_vld=0 immediately. After release, a new request arbitrates from ptr=0.
- Valid drop: vld1 deasserts for 3 cycles mid-packet in G1. Expect gnt=10 held, q_vld=0 during the gap, and no grant to a pending vld0.
